// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and operand-signedness helpers for the RV32M
// multiply/divide execution unit.
package muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Bit 2 of funct3 separates the divide family from the multiply family.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Decode-to-execute bundle for the M-extension unit: operation request in,
// stall and register write-back out.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            flush_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_i;
    logic            busy_o;
    logic            wr_en_o;
    logic [4:0]      wr_addr_o;
    logic [XLEN-1:0] wr_data_o;

    modport master (
        output start_i, flush_i, funct3_i, op1_i, op2_i, rd_i,
        input  busy_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  start_i, flush_i, funct3_i, op1_i, op2_i, rd_i,
        output busy_o, wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/muldiv_iter_div.sv
// Restoring unsigned divider datapath: one quotient bit per step. Operates on
// magnitudes; sign fix-up and sequencing belong to the owning FSM.
module muldiv_iter_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot_nxt,
    output logic [XLEN-1:0] o_rem_nxt
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_divisor;

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;

    // The dividend shifts out of the quotient register MSB-first while the
    // quotient bits shift in at the bottom.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_rem_nxt  = w_shift[XLEN-1:0];
        o_quot_nxt = {r_quot[XLEN-2:0], 1'b0};
        if (!w_diff[XLEN]) begin
            o_rem_nxt  = w_diff[XLEN-1:0];
            o_quot_nxt = {r_quot[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
        end else if (i_step) begin
            r_rem     <= o_rem_nxt;
            r_quot    <= o_quot_nxt;
        end
    end

endmodule

// File: rtl/muldiv_exec.sv
// Iterative RV32M execution unit: shift-add multiply, restoring divide, single
// cycle write-back. Define MULDIV_FAST_MUL_EN for a one-cycle multiplier.
module muldiv_exec
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic [4:0]        r_rd;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [4:0]        r_wr_addr;
    logic [XLEN-1:0]   r_wr_data;

    logic              w_accept;
    logic              w_last;
    logic              w_div_load;
    logic              w_div_step;

    logic              w_op1_signed;
    logic              w_op2_signed;
    logic              w_op1_neg;
    logic              w_op2_neg;
    logic              w_is_div;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_shortcut;
    logic              w_fast_hit;
    logic              w_jump;
    logic [XLEN-1:0]   w_op1_mag;
    logic [XLEN-1:0]   w_op2_mag;
    logic [XLEN-1:0]   w_short_data;
    logic [XLEN-1:0]   w_fast_data;
    logic [XLEN-1:0]   w_accept_data;

    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_div_q_nxt;
    logic [XLEN-1:0]   w_div_r_nxt;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_result;

    // ---------------- accept-time operand conditioning ----------------
    assign w_op1_signed = op1_is_signed(bus.funct3_i);
    assign w_op2_signed = op2_is_signed(bus.funct3_i);
    assign w_op1_neg    = w_op1_signed & bus.op1_i[XLEN-1];
    assign w_op2_neg    = w_op2_signed & bus.op2_i[XLEN-1];
    assign w_op1_mag    = w_op1_neg ? -bus.op1_i : bus.op1_i;
    assign w_op2_mag    = w_op2_neg ? -bus.op2_i : bus.op2_i;
    assign w_is_div     = is_div_op(bus.funct3_i);

    assign w_div_zero   = w_is_div && (bus.op2_i == '0);
    assign w_div_ovf    = w_is_div && w_op2_signed
                       && (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op2_i);
    assign w_shortcut   = w_div_zero | w_div_ovf;

    // funct3[1] distinguishes REM/REMU from DIV/DIVU within the divide family.
    assign w_short_data = w_div_zero ? (bus.funct3_i[1] ? bus.op1_i : '1)
                                     : (bus.funct3_i[1] ? '0 : bus.op1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_a;
    logic [2*XLEN-1:0] w_fast_b;
    logic [2*XLEN-1:0] w_fast_prod;

    // Sign-extended operands give the exact product modulo 2^(2*XLEN).
    assign w_fast_a    = {{XLEN{w_op1_neg}}, bus.op1_i};
    assign w_fast_b    = {{XLEN{w_op2_neg}}, bus.op2_i};
    assign w_fast_prod = w_fast_a * w_fast_b;
    assign w_fast_hit  = !w_is_div;
    assign w_fast_data = (bus.funct3_i == F3_MUL) ? w_fast_prod[XLEN-1:0]
                                                  : w_fast_prod[2*XLEN-1:XLEN];
`else
    assign w_fast_hit  = 1'b0;
    assign w_fast_data = '0;
`endif

    assign w_jump        = w_shortcut | w_fast_hit;
    assign w_accept_data = w_shortcut ? w_short_data : w_fast_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_div_load  = 1'b0;
        w_div_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_accept    = 1'b1;
                    w_div_load  = w_is_div;
                    w_state_nxt = w_jump ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_div_step = is_div_op(r_f3);
                if (r_cnt == CNT_W'(XLEN-1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // A flush beats everything, including a same-cycle start.
        if (bus.flush_i) begin
            w_state_nxt = ST_IDLE;
            w_accept    = 1'b0;
            w_last      = 1'b0;
            w_div_load  = 1'b0;
            w_div_step  = 1'b0;
        end
    end

    // ---------------- datapaths ----------------
    muldiv_iter_div #(
        .XLEN (XLEN)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_div_load),
        .i_step     (w_div_step),
        .i_dividend (w_op1_mag),
        .i_divisor  (w_op2_mag),
        .o_quot_nxt (w_div_q_nxt),
        .o_rem_nxt  (w_div_r_nxt)
    );

    // Shift-add: the multiplier sits in the low half and drains out as the
    // partial product shifts in from the top.
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};

    assign w_prod     = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quot_fix = r_neg_q ? -w_div_q_nxt : w_div_q_nxt;
    assign w_rem_fix  = r_neg_r ? -w_div_r_nxt : w_div_r_nxt;

    always_comb begin
        w_result = w_rem_fix;
        case (r_f3)
            F3_MUL:                        w_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  w_result = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               w_result = w_quot_fix;
            default:                       w_result = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_f3      <= '0;
            r_rd      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_f3    <= bus.funct3_i;
            r_rd    <= bus.rd_i;
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
            r_mcand <= w_op1_mag;
            r_acc   <= {{XLEN{1'b0}}, w_op2_mag};
            if (w_jump) begin
                r_wr_addr <= bus.rd_i;
                r_wr_data <= w_accept_data;
            end
        end else if (r_state == ST_BUSY && !bus.flush_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (!is_div_op(r_f3)) begin
                r_acc <= w_acc_nxt;
            end
            if (w_last) begin
                r_wr_addr <= r_rd;
                r_wr_data <= w_result;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.busy_o    = (r_state != ST_IDLE);
    assign bus.wr_en_o   = (r_state == ST_DONE) && (r_rd != 5'd0) && !bus.flush_i;
    assign bus.wr_addr_o = r_wr_addr;
    assign bus.wr_data_o = r_wr_data;

endmodule

// File: tb/tb_muldiv_exec.sv
// Scoreboard bench for muldiv_exec: expected write-backs are queued at issue
// and matched against each wr_en_o pulse, including latency and busy length.
module tb_muldiv_exec;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus();

    muldiv_exec #(
        .XLEN  (XLEN),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, p;
        longint      sa, sbv;
        logic        ovf;
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sa  = $signed(a);
        sbv = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            F3_MUL:    begin p = ua * ub;  return p[31:0];  end
            F3_MULH:   begin p = sa * sbv; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub;  return p[63:32]; end
            F3_MULHU:  begin p = ua * ub;  return p[63:32]; end
            F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 1;
            if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return XLEN + 1;
`endif
    endfunction

    // Write-back monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.wr_en_o === 1'b1) begin
            if (q_exp.size() == 0) begin
                check("unexpected_wr", bus.wr_en_o, 1'b0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("wr_data", bus.wr_data_o, e.data);
                check("wr_addr", bus.wr_addr_o, e.addr);
                check("wr_latency", cyc - acc_cyc + 1, e.lat);
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = f3;
        bus.op1_i    = a;
        bus.op2_i    = b;
        bus.rd_i     = rd;
        @(posedge clk);
        #1 acc_cyc = cyc;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit poke);
        exp_t e;
        int   busy_cnt;
        int   lat;
        lat    = model_lat(f3, a, b);
        e.data = model(f3, a, b);
        e.addr = rd;
        e.lat  = lat;
        if (rd != 5'd0) q_exp.push_back(e);
        issue(f3, a, b, rd);
        @(negedge clk);
        bus.start_i = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy_o !== 1'b1) break;
            busy_cnt++;
            // A stalled decode may present a different op; it must be ignored.
            if (poke && i == 3) begin
                bus.start_i  = 1'b1;
                bus.funct3_i = ~f3;
                bus.op1_i    = 32'h1234_5678;
                bus.op2_i    = 32'h0000_0003;
                bus.rd_i     = 5'd31;
            end else begin
                bus.start_i  = 1'b0;
            end
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        check("busy_cycles", busy_cnt, lat);
        check("sb_drained", q_exp.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.funct3_i = '0;
        bus.op1_i    = '0;
        bus.op2_i    = '0;
        bus.rd_i     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_wr_en", bus.wr_en_o, 1'b0);
        check("rst_wr_addr", bus.wr_addr_o, 5'd0);
        check("rst_wr_data", bus.wr_data_o, 32'd0);
        rst = 1'b0;

        run_op(F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  1'b0);
        run_op(F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  1'b0);
        run_op(F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  1'b0);
        run_op(F3_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  1'b0);
        run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  1'b0);
        run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 1'b0);
        run_op(F3_DIVU,   32'd100,       32'd7,         5'd11, 1'b1);
        run_op(F3_REMU,   32'd100,       32'd7,         5'd12, 1'b0);
        run_op(F3_DIV,    32'd5,         32'd0,         5'd13, 1'b0);
        run_op(F3_REMU,   32'd5,         32'd0,         5'd14, 1'b0);
        run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
        run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);
        run_op(F3_MUL,    32'd3,         32'd3,         5'd0,  1'b1);
        run_op(F3_MULH,   32'd3,         32'h8000_0001, 5'd17, 1'b1);

        // Flush ten cycles into a divide: no write-back, idle next cycle.
        issue(F3_DIVU, 32'd1000, 32'd9, 5'd20);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_busy", bus.busy_o, 1'b0);
        check("flush_wr_en", bus.wr_en_o, 1'b0);
        run_op(F3_DIVU, 32'd1000, 32'd9, 5'd21, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            run_op(f3, a, b, 5'(i + 1), 1'b0);
        end

        // Reset in the middle of an operation clears every output.
        issue(F3_MULHU, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd22);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("midop_busy", bus.busy_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy_o, 1'b0);
        check("midrst_wr_en", bus.wr_en_o, 1'b0);
        check("midrst_wr_addr", bus.wr_addr_o, 5'd0);
        check("midrst_wr_data", bus.wr_data_o, 32'd0);
        rst = 1'b0;
        run_op(F3_REM, 32'd100, 32'hFFFF_FFF9, 5'd23, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
